hyperbus_ax_splitter: RTL and testbench

//  Sits between the AXI slave front-end and the hyperbus transaction engine.

---
 rtl/hyperbus_ax_splitter.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_hyperbus_ax_splitter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_ax_splitter.sv
// hyperbus_ax_splitter
// Breaks AXI AR/AW bursts into fragments that stay inside one MaxBytes-aligned
// page and never exceed MaxBytes, then folds the per-fragment responses back
// into one response per original burst. A single in-order FIFO records, per
// issued fragment, whether it was the final fragment of its burst.
module hyperbus_ax_splitter #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 128,
  parameter int MaxBytes  = 1024,
  parameter int MaxTxns   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic [7:0]           in_len_i,
  input  logic [2:0]           in_size_i,
  input  logic [1:0]           in_burst_i,
  input  logic                 in_write_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic [7:0]           out_len_o,
  output logic [2:0]           out_size_o,
  output logic [1:0]           out_burst_o,
  output logic                 out_write_o,
  output logic                 out_last_o,
  input  logic                 dn_b_valid_i,
  output logic                 dn_b_ready_o,
  input  logic [1:0]           dn_b_resp_i,
  output logic                 up_b_valid_o,
  input  logic                 up_b_ready_i,
  output logic [1:0]           up_b_resp_o,
  input  logic                 dn_r_valid_i,
  output logic                 dn_r_ready_o,
  input  logic [DataWidth-1:0] dn_r_data_i,
  input  logic [1:0]           dn_r_resp_i,
  input  logic                 dn_r_last_i,
  output logic                 up_r_valid_o,
  input  logic                 up_r_ready_i,
  output logic [DataWidth-1:0] up_r_data_o,
  output logic [1:0]           up_r_resp_o,
  output logic                 up_r_last_o
);

  localparam logic [1:0]           BurstIncr = 2'b01;
  localparam int                   PtrW      = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int                   CntW      = $clog2(MaxTxns + 1);
  localparam logic [AddrWidth-1:0] PageMask  = AddrWidth'(MaxBytes - 1);
  localparam logic [AddrWidth:0]   PageBytes = (AddrWidth + 1)'(MaxBytes);

  typedef enum logic [0:0] {StIdle = 1'b0, StSplit = 1'b1} state_e;

  // Beats of the fragment starting at addr: INCR stops at the page edge,
  // FIXED/WRAP always go out whole.
  function automatic logic [8:0] frag_beats(input logic [AddrWidth-1:0] addr,
                                            input logic [8:0]           rem,
                                            input logic [2:0]           size,
                                            input logic [1:0]           burst);
    logic [AddrWidth-1:0] al;
    logic [AddrWidth:0]   room;
    al   = addr & ~((AddrWidth'(1) << size) - AddrWidth'(1));
    room = (PageBytes - {1'b0, al & PageMask}) >> size;
    if (burst != BurstIncr) begin
      frag_beats = rem;
    end else if ({{(AddrWidth - 8){1'b0}}, rem} < room) begin
      frag_beats = rem;
    end else begin
      frag_beats = room[8:0];
    end
  endfunction

  // Start address of the fragment that follows one of 'beats' beats at addr.
  function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                     input logic [8:0]           beats,
                                                     input logic [2:0]           size);
    logic [AddrWidth-1:0] al;
    al        = addr & ~((AddrWidth'(1) << size) - AddrWidth'(1));
    next_addr = al + ({{(AddrWidth - 9){1'b0}}, beats} << size);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(MaxTxns - 1)) begin
      ptr_inc = PtrW'(0);
    end else begin
      ptr_inc = ptr + PtrW'(1);
    end
  endfunction

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [8:0]           rem_q, rem_d;
  logic [7:0]           len_q, len_d;
  logic                 last_q, last_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic                 write_q, write_d;

  logic                 fifo_q [MaxTxns];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           acc_q, acc_d;

  logic                 fifo_full_s, fifo_empty_s, head_last_s;
  logic                 in_hs_s, out_hs_s, dn_b_hs_s, pop_s;
  logic [1:0]           b_resp_max_s;
  logic [8:0]           in_rem_s, in_beats_s, cur_beats_s, adv_rem_s, adv_beats_s;
  logic [AddrWidth-1:0] adv_addr_s;

  // Handshake qualifiers and fragment outputs taken straight from the command registers.
  always_comb begin
    fifo_full_s  = (cnt_q == CntW'(MaxTxns));
    fifo_empty_s = (cnt_q == CntW'(0));
    head_last_s  = !fifo_empty_s && fifo_q[rd_ptr_q];
    in_ready_o   = (state_q == StIdle);
    out_valid_o  = (state_q == StSplit) && !fifo_full_s;
    in_hs_s      = in_valid_i && in_ready_o;
    out_hs_s     = out_valid_o && out_ready_i;
    out_addr_o   = addr_q;
    out_len_o    = len_q;
    out_size_o   = size_q;
    out_burst_o  = burst_q;
    out_write_o  = write_q;
    out_last_o   = last_q;
  end

  // Split FSM: latch a command, then walk it fragment by fragment.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    len_d       = len_q;
    last_d      = last_q;
    size_d      = size_q;
    burst_d     = burst_q;
    write_d     = write_q;
    in_rem_s    = {1'b0, in_len_i} + 9'd1;
    in_beats_s  = frag_beats(in_addr_i, in_rem_s, in_size_i, in_burst_i);
    cur_beats_s = {1'b0, len_q} + 9'd1;
    adv_addr_s  = next_addr(addr_q, cur_beats_s, size_q);
    adv_rem_s   = rem_q - cur_beats_s;
    adv_beats_s = frag_beats(adv_addr_s, adv_rem_s, size_q, burst_q);
    case (state_q)
      StIdle: begin
        if (in_hs_s) begin
          state_d = StSplit;
          addr_d  = in_addr_i;
          rem_d   = in_rem_s;
          len_d   = 8'(in_beats_s - 9'd1);
          last_d  = (in_rem_s == in_beats_s);
          size_d  = in_size_i;
          burst_d = in_burst_i;
          write_d = in_write_i;
        end else begin
          state_d = StIdle;
        end
      end
      StSplit: begin
        if (out_hs_s && last_q) begin
          state_d = StIdle;
        end else if (out_hs_s) begin
          addr_d = adv_addr_s;
          rem_d  = adv_rem_s;
          len_d  = 8'(adv_beats_s - 9'd1);
          last_d = (adv_rem_s == adv_beats_s);
        end else begin
          state_d = StSplit;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Command and current-fragment registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= AddrWidth'(0);
      rem_q   <= 9'd0;
      len_q   <= 8'd0;
      last_q  <= 1'b0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      last_q  <= last_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      write_q <= write_d;
    end
  end

  // Response merge: B beats of non-final fragments are absorbed, the final one
  // carries the worst response seen; R passes through with last gated.
  always_comb begin
    dn_b_hs_s = dn_b_valid_i && dn_b_ready_o;
    if (dn_b_resp_i > acc_q) begin
      b_resp_max_s = dn_b_resp_i;
    end else begin
      b_resp_max_s = acc_q;
    end
    if (head_last_s) begin
      dn_b_ready_o = up_b_ready_i;
    end else begin
      dn_b_ready_o = 1'b1;
    end
    up_b_valid_o = dn_b_valid_i && head_last_s;
    if (up_b_valid_o) begin
      up_b_resp_o = b_resp_max_s;
    end else begin
      up_b_resp_o = 2'b00;
    end
    up_r_valid_o = dn_r_valid_i;
    up_r_data_o  = dn_r_data_i;
    up_r_resp_o  = dn_r_resp_i;
    up_r_last_o  = dn_r_last_i && head_last_s;
    dn_r_ready_o = up_r_ready_i;
    pop_s        = !fifo_empty_s &&
                   (dn_b_hs_s || (dn_r_valid_i && up_r_ready_i && dn_r_last_i));
  end

  // Tracking FIFO pointers, occupancy and B error accumulator next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    if (out_hs_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (out_hs_s && !pop_s) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!out_hs_s && pop_s) begin
      cnt_d = cnt_q - CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (dn_b_hs_s && head_last_s) begin
      acc_d = 2'b00;
    end else if (dn_b_hs_s) begin
      acc_d = b_resp_max_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Tracking FIFO storage and bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxTxns; i++) begin
        fifo_q[i] <= 1'b0;
      end
      wr_ptr_q <= PtrW'(0);
      rd_ptr_q <= PtrW'(0);
      cnt_q    <= CntW'(0);
      acc_q    <= 2'b00;
    end else begin
      if (out_hs_s) begin
        fifo_q[wr_ptr_q] <= last_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_hyperbus_ax_splitter.sv
// Bench for hyperbus_ax_splitter: a page-walking reference model predicts the
// fragments and merged responses; a bench-side engine answers fragments; a
// monitor compares everything the DUT presents against the expectation queues.
module tb_hyperbus_ax_splitter;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int MB = 1024;
  localparam int MT = 2;
  localparam int PgShift = $clog2(MB);

  typedef struct packed {
    logic [31:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic write; logic last; logic [1:0] resp;
  } frag_t;
  typedef struct packed { logic [1:0] resp; logic [7:0] nfrags; } expb_t;
  typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; logic last; } rbeat_t;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid_i, in_ready_o, in_write_i;
  logic [AW-1:0] in_addr_i, out_addr_o;
  logic [7:0] in_len_i, out_len_o;
  logic [2:0] in_size_i, out_size_o;
  logic [1:0] in_burst_i, out_burst_o;
  logic out_valid_o, out_ready_i, out_write_o, out_last_o;
  logic dn_b_valid_i, dn_b_ready_o, up_b_valid_o, up_b_ready_i;
  logic [1:0] dn_b_resp_i, up_b_resp_o, dn_r_resp_i, up_r_resp_o;
  logic dn_r_valid_i, dn_r_ready_o, dn_r_last_i, up_r_valid_o, up_r_ready_i, up_r_last_o;
  logic [DW-1:0] dn_r_data_i, up_r_data_o;

  frag_t  exp_frag_q[$];
  frag_t  eng_q[$];
  expb_t  exp_b_q[$];
  rbeat_t exp_r_q[$];
  logic [1:0] force_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int credits = -1;
  bit rand_bp = 1'b0, eng_busy = 1'b0;
  int frag_hs_cnt = 0, last_frag_cyc = 0, last_dnb_cyc = 0, dnb_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hyperbus_ax_splitter #(.AddrWidth(AW), .DataWidth(DW), .MaxBytes(MB), .MaxTxns(MT)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
    .in_len_i(in_len_i), .in_size_i(in_size_i), .in_burst_i(in_burst_i), .in_write_i(in_write_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_addr_o(out_addr_o),
    .out_len_o(out_len_o), .out_size_o(out_size_o), .out_burst_o(out_burst_o),
    .out_write_o(out_write_o), .out_last_o(out_last_o),
    .dn_b_valid_i(dn_b_valid_i), .dn_b_ready_o(dn_b_ready_o), .dn_b_resp_i(dn_b_resp_i),
    .up_b_valid_o(up_b_valid_o), .up_b_ready_i(up_b_ready_i), .up_b_resp_o(up_b_resp_o),
    .dn_r_valid_i(dn_r_valid_i), .dn_r_ready_o(dn_r_ready_o), .dn_r_data_i(dn_r_data_i),
    .dn_r_resp_i(dn_r_resp_i), .dn_r_last_i(dn_r_last_i),
    .up_r_valid_o(up_r_valid_o), .up_r_ready_i(up_r_ready_i), .up_r_data_o(up_r_data_o),
    .up_r_resp_o(up_r_resp_o), .up_r_last_o(up_r_last_o)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: walk the burst beat by beat; a new fragment starts whenever a
  // beat lands in a different MaxBytes page than the previous beat.
  task automatic model_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic w);
    logic [31:0] st_q[$];
    int cn_q[$];
    logic [31:0] al, ba, prev_pg;
    int bs, cnt;
    logic [1:0] worst, r;
    frag_t f;
    expb_t eb;
    bs = 1 << s;
    al = a & ~(32'(bs) - 32'd1);
    if (b != 2'b01) begin
      st_q.push_back(a); cn_q.push_back(int'(l) + 1);
    end else begin
      st_q.push_back(a); cnt = 0; prev_pg = a >> PgShift;
      for (int i = 0; i <= int'(l); i++) begin
        ba = (i == 0) ? a : al + 32'(i * bs);
        if ((ba >> PgShift) != prev_pg) begin
          cn_q.push_back(cnt); st_q.push_back(ba); cnt = 0; prev_pg = ba >> PgShift;
        end
        cnt++;
      end
      cn_q.push_back(cnt);
    end
    worst = 2'b00;
    for (int j = 0; j < st_q.size(); j++) begin
      r = 2'b00;
      if (w && force_q.size() > 0) r = force_q.pop_front();
      else if (w) r = 2'($urandom_range(0, 3));
      if (r > worst) worst = r;
      f.addr = st_q[j]; f.len = 8'(cn_q[j] - 1); f.size = s; f.burst = b; f.write = w;
      f.last = (j == st_q.size() - 1); f.resp = r;
      exp_frag_q.push_back(f);
    end
    if (w) begin
      eb.resp = worst; eb.nfrags = 8'(st_q.size());
      exp_b_q.push_back(eb);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic w);
    int n;
    model_cmd(a, l, s, b, w);
    @(posedge clk); #1;
    in_valid_i = 1'b1; in_addr_i = a; in_len_i = l; in_size_i = s; in_burst_i = b; in_write_i = w;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready_o && n < 5000);
    chk("in_accept_timeout", 160'(n >= 5000), 160'(0));
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_frag_q.size() != 0 || eng_q.size() != 0 || exp_b_q.size() != 0 ||
            exp_r_q.size() != 0 || eng_busy) && n < 30000) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", 160'(n >= 30000), 160'(0));
  endtask

  // Ready drivers: either always ready or random back-pressure.
  initial begin
    out_ready_i = 1'b1; up_b_ready_i = 1'b1; up_r_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rand_bp) begin
        out_ready_i  = ($urandom_range(0, 3) != 0);
        up_b_ready_i = ($urandom_range(0, 2) != 0);
        up_r_ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready_i = 1'b1; up_b_ready_i = 1'b1; up_r_ready_i = 1'b1;
      end
    end
  end

  // Downstream engine: answers issued fragments in order, one B per write
  // fragment, len+1 R beats per read fragment.
  initial begin
    frag_t f;
    rbeat_t rb;
    int n;
    dn_b_valid_i = 1'b0; dn_b_resp_i = 2'b00; dn_r_valid_i = 1'b0;
    dn_r_data_i = '0; dn_r_resp_i = 2'b00; dn_r_last_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && credits != 0 && eng_q.size() > 0) begin
        f = eng_q.pop_front(); eng_busy = 1'b1;
        if (credits > 0) credits--;
        if (f.write) begin
          dn_b_valid_i = 1'b1; dn_b_resp_i = f.resp;
          n = 0;
          do begin @(negedge clk); n++; end while (!dn_b_ready_o && n < 2000);
          chk("dn_b_timeout", 160'(n >= 2000), 160'(0));
          @(posedge clk); #1;
          dn_b_valid_i = 1'b0;
        end else begin
          for (int k = 0; k <= int'(f.len); k++) begin
            rb.data = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb.resp = 2'($urandom_range(0, 3));
            rb.last = f.last && (k == int'(f.len));
            dn_r_valid_i = 1'b1; dn_r_data_i = rb.data; dn_r_resp_i = rb.resp;
            dn_r_last_i = (k == int'(f.len));
            exp_r_q.push_back(rb);
            n = 0;
            do begin @(negedge clk); n++; end while (!dn_r_ready_o && n < 2000);
            chk("dn_r_timeout", 160'(n >= 2000), 160'(0));
            @(posedge clk); #1;
          end
          dn_r_valid_i = 1'b0; dn_r_last_i = 1'b0;
        end
        eng_busy = 1'b0;
      end
    end
  end

  // Monitor: compares presented fragments (every cycle, so stalls are covered)
  // and upstream B/R handshakes against the expectation queues.
  initial begin
    frag_t f;
    expb_t eb;
    rbeat_t rb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid_o) begin
          if (exp_frag_q.size() == 0) begin
            chk("unexpected_frag", {out_addr_o, out_len_o}, 160'(0));
          end else begin
            f = exp_frag_q[0];
            chk("frag", {out_addr_o, out_len_o, out_size_o, out_burst_o, out_write_o, out_last_o},
                {f.addr, f.len, f.size, f.burst, f.write, f.last});
            if (out_ready_i) begin
              void'(exp_frag_q.pop_front());
              eng_q.push_back(f);
              frag_hs_cnt++; last_frag_cyc = cyc;
            end
          end
        end
        if (dn_b_valid_i && dn_b_ready_o) begin
          dnb_cnt++; last_dnb_cyc = cyc;
        end
        if (up_b_valid_o && up_b_ready_i) begin
          if (exp_b_q.size() == 0) begin
            chk("unexpected_up_b", 160'(up_b_resp_o), 160'(4));
          end else begin
            eb = exp_b_q.pop_front();
            chk("up_b_resp", 160'(up_b_resp_o), 160'(eb.resp));
            chk("up_b_after_all_dn_b", 160'(dnb_cnt), 160'(eb.nfrags));
          end
          dnb_cnt = 0;
        end
        if (up_r_valid_o && up_r_ready_i) begin
          if (exp_r_q.size() == 0) begin
            chk("unexpected_up_r", 160'(up_r_last_o), 160'(2));
          end else begin
            rb = exp_r_q.pop_front();
            chk("up_r", {up_r_data_o, up_r_resp_o, up_r_last_o}, {rb.data, rb.resp, rb.last});
          end
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int base, n;
    logic [31:0] a;
    logic [7:0] l;
    int r;
    in_valid_i = 1'b0; in_addr_i = '0; in_len_i = 8'd0; in_size_i = 3'd0;
    in_burst_i = 2'b00; in_write_i = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 160'(in_ready_o), 160'(1));
    chk("reset_out_valid", 160'(out_valid_o), 160'(0));
    chk("reset_up_b_valid", 160'(up_b_valid_o), 160'(0));
    chk("reset_out_fields", {out_addr_o, out_len_o, out_last_o}, 160'(0));
    rst = 1'b0;

    // T1..T4 without back-pressure
    send_cmd(32'h0000_0A00, 8'd255, 3'd4, 2'b01, 1'b0);
    send_cmd(32'h0000_03FE, 8'd3, 3'd2, 2'b01, 1'b1);
    force_q.push_back(2'b00); force_q.push_back(2'b10); force_q.push_back(2'b00);
    send_cmd(32'h0000_0300, 8'd127, 3'd4, 2'b01, 1'b1);
    send_cmd(32'h0000_03F0, 8'd7, 3'd2, 2'b01, 1'b0);
    send_cmd(32'h0000_03F8, 8'd7, 3'd3, 2'b00, 1'b1);
    send_cmd(32'h0000_07F0, 8'd3, 3'd2, 2'b10, 1'b0);
    drain();

    // T5: tracking FIFO full stalls issue; one response frees one slot
    credits = 0;
    base = frag_hs_cnt;
    send_cmd(32'h0000_0000, 8'd255, 3'd4, 2'b01, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("fifo_full_frag_count", 160'(frag_hs_cnt - base), 160'(2));
    chk("fifo_full_out_valid", 160'(out_valid_o), 160'(0));
    credits = 1;
    n = 0;
    while (frag_hs_cnt - base < 3 && n < 100) begin @(negedge clk); n++; end
    chk("third_frag_timeout", 160'(n >= 100), 160'(0));
    chk("third_frag_latency", 160'(last_frag_cyc), 160'(last_dnb_cyc + 1));
    credits = -1;
    drain();

    // T6: back-pressure, then reset in the middle of a split
    rand_bp = 1'b1;
    send_cmd(32'h0000_1F40, 8'd200, 3'd3, 2'b01, 1'b0);
    send_cmd(32'h0000_0BFC, 8'd99, 3'd2, 2'b01, 1'b1);
    drain();
    credits = 0;
    send_cmd(32'h0000_0A00, 8'd255, 3'd4, 2'b01, 1'b0);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_out_valid", 160'(out_valid_o), 160'(0));
    chk("midreset_in_ready", 160'(in_ready_o), 160'(1));
    chk("midreset_up_b_valid", 160'(up_b_valid_o), 160'(0));
    chk("midreset_out_fields", {out_addr_o, out_len_o, out_last_o}, 160'(0));
    exp_frag_q.delete(); eng_q.delete(); exp_b_q.delete(); exp_r_q.delete(); force_q.delete();
    dnb_cnt = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    credits = -1;
    send_cmd(32'h0000_03FE, 8'd3, 3'd2, 2'b01, 1'b1);
    send_cmd(32'h0000_0A00, 8'd255, 3'd4, 2'b01, 1'b0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 32'h0FFF_FFFF))
                                      : 32'($urandom_range(0, 32'h3FFF));
      l = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      r = $urandom_range(0, 7);
      send_cmd(a, l, 3'($urandom_range(0, 4)),
               (r < 5) ? 2'b01 : ((r < 6) ? 2'b00 : 2'b10), 1'($urandom_range(0, 1)));
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
